// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared types and constants for the UART transmit scheduler
// Purpose: scheduler state encoding, default parameter values and timer width
// shared by the scheduler top, its requester interface and the round-robin arbiter.
// Ports: none (package).
package uart_ctrl_pkg;

  localparam int DEFAULT_NUM_REQ       = 4;
  localparam int DEFAULT_START_TIMEOUT = 65535;
  localparam int TIMER_W               = 32;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } eSchedState;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester-side bus of the UART transmit scheduler
// Purpose: bundles the per-requester byte handshake shared by NUM_REQ requesters.
// Signals:
//   req_valid  [NUM_REQ]    byte pending on requester i, held until its req_ready pulse
//   req_data   [8*NUM_REQ]  byte of requester i on bits [8i+7:8i]
//   req_ready  [NUM_REQ]    one-cycle accept pulse, at most one bit high
// Modports: master = requesters, slave = scheduler.
interface uart_tx_scheduler_if
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Purpose: selects the first asserted request at or after ptr, wrapping at NUM_REQ-1.
// Ports:
//   req        request vector
//   ptr        index with highest priority this cycle
//   grant      one-hot winner (all zero when nothing requests)
//   grant_idx  binary index of the winner
//   any_grant  at least one request present
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int  NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_grant
);

  logic [IDW-1:0] idx;

  // Walk the requesters in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte scheduler in front of one UART transmitter
// Purpose: accepts bytes from NUM_REQ requesters in round-robin order, hands each
// to the transmitter with a start strobe and waits for the frame to finish. A
// transmitter that never leaves idle after a strobe raises a sticky timeout.
// Ports:
//   clock, reset_n  system clock, synchronous active-low reset
//   req_bus         requester handshake (slave modport)
//   tx_send         one-cycle start strobe to the transmitter
//   tx_data         byte presented to the transmitter
//   tx_complete     transmitter idle flag (1 = idle, 0 = frame in progress)
//   grant_id        requester currently or last served
//   busy            scheduler not in IDLE
//   err_timeout     sticky: transmitter failed to start a frame
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int  NUM_REQ       = DEFAULT_NUM_REQ,
  parameter int  START_TIMEOUT = DEFAULT_START_TIMEOUT,
  localparam int IDW           = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  uart_tx_scheduler_if.slave req_bus,
  output logic               tx_send,
  output logic [7:0]         tx_data,
  input  logic               tx_complete,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               err_timeout
);

  eSchedState           state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
  logic                 timeout_hit;

  logic                 tx_send_d;
  logic [7:0]           tx_data_d;
  logic [NUM_REQ-1:0]   req_ready_d;
  logic [IDW-1:0]       grant_id_d;
  logic                 err_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDW-1:0]       arb_idx;
  logic                 arb_any;
  logic [IDW-1:0]       next_ptr;
  logic [7:0]           arb_byte;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign arb_byte = req_bus.req_data[{arb_idx, 3'b000} +: 8];

  // Priority moves to the requester after the one just served, wrapping to 0.
  assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

  // Saturating increment so a stuck transmitter can never wrap the timer.
  assign timer_inc   = (&timer_q) ? timer_q : timer_q + TIMER_W'(1);
  // The ISSUE clock plus START_TIMEOUT-1 idle WAIT_BUSY clocks put the error
  // START_TIMEOUT clocks after the strobe.
  assign timeout_hit = (timer_inc >= TIMER_W'(START_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    tx_send_d   = 1'b0;
    tx_data_d   = tx_data;
    req_ready_d = '0;
    grant_id_d  = grant_id;
    err_d       = err_timeout;

    case (state_q)
      S_IDLE: begin
        // A low tx_complete here means a frame from before a reset is still
        // on the line; hold every request until it finishes.
        if (tx_complete && arb_any) begin
          req_ready_d = arb_grant;
          tx_data_d   = arb_byte;
          grant_id_d  = arb_idx;
          tx_send_d   = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_complete) begin
          state_d = S_WAIT_DONE;
        end else begin
          timer_d = timer_inc;
          if (timeout_hit) begin
            // Byte is dropped; the requester already saw its accept pulse.
            err_d    = 1'b1;
            rr_ptr_d = next_ptr;
            state_d  = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (tx_complete) begin
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      rr_ptr_q          <= '0;
      timer_q           <= '0;
      tx_send           <= 1'b0;
      tx_data           <= '0;
      req_bus.req_ready <= '0;
      grant_id          <= '0;
      busy              <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      timer_q           <= timer_d;
      tx_send           <= tx_send_d;
      tx_data           <= tx_data_d;
      req_bus.req_ready <= req_ready_d;
      grant_id          <= grant_id_d;
      busy              <= (state_d != S_IDLE);
      err_timeout       <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  localparam int NR = 4;

  logic       clock;
  logic       reset_n;
  logic       tx_complete;
  logic       tx_send;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  logic       busy;
  logic       err_timeout;

  uart_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NR), .START_TIMEOUT(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_bus     (bus),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .tx_complete (tx_complete),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  int total = 0;
  int bad   = 0;

  bit model_dead = 1'b0;
  int drop_at    = 3;
  int rise_at    = 43;

  int send_bad  = 0;
  int ready_bad = 0;
  int rdy2_cnt  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Transmitter model: complete drops drop_at clocks after tx_send, rises at rise_at.
  initial begin
    int  cnt;
    bit  active;
    tx_complete = 1'b1;
    active      = 1'b0;
    cnt         = 0;
    forever begin
      @(posedge clock);
      #1;
      if (active) begin
        cnt++;
        if (cnt == drop_at) tx_complete = 1'b0;
        if (cnt == rise_at) begin
          tx_complete = 1'b1;
          active      = 1'b0;
        end
      end else if (tx_send === 1'b1 && !model_dead) begin
        active = 1'b1;
        cnt    = 0;
      end
    end
  end

  // Protocol monitor: strobe only while idle, strobes at least 4 clocks apart,
  // accept pulses one-hot.
  initial begin
    int cyc;
    int last_send;
    cyc       = 0;
    last_send = -100;
    forever begin
      @(negedge clock);
      cyc++;
      if (tx_send === 1'b1) begin
        if (tx_complete !== 1'b1) send_bad++;
        if (cyc - last_send < 4) send_bad++;
        last_send = cyc;
      end
      if (!$onehot0(bus.req_ready)) ready_bad++;
      if (bus.req_ready[2] === 1'b1) rdy2_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_send(input string tag, input int bound, output int waited);
    waited = 0;
    while (tx_send !== 1'b1 && waited < bound) begin
      tick(1);
      waited++;
    end
    check({tag, " strobe seen"}, 32'(tx_send), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick(1);
      n++;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " tx_send"},     32'(tx_send),       32'd0);
    check({tag, " tx_data"},     32'(tx_data),       32'd0);
    check({tag, " req_ready"},   32'(bus.req_ready), 32'd0);
    check({tag, " grant_id"},    32'(grant_id),      32'd0);
    check({tag, " busy"},        32'(busy),          32'd0);
    check({tag, " err_timeout"}, 32'(err_timeout),   32'd0);
  endtask

  initial begin
    int w;
    int r2;
    int viol;

    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    tick(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Single request from requester 1.
    bus.req_data  = 32'h0000_5A00;
    bus.req_valid = 4'b0010;
    tick(1);
    check("single req_ready", 32'(bus.req_ready), 32'h2);
    check("single tx_send",   32'(tx_send),       32'd1);
    check("single tx_data",   32'(tx_data),       32'h5A);
    check("single grant_id",  32'(grant_id),      32'd1);
    check("single busy",      32'(busy),          32'd1);
    bus.req_valid = '0;
    tick(1);
    check("single req_ready pulse", 32'(bus.req_ready), 32'd0);
    check("single tx_send pulse",   32'(tx_send),       32'd0);
    w = 1;
    while (busy === 1'b1 && w < 200) begin
      tick(1);
      w++;
    end
    check("single idle latency", 32'(w), 32'd44);
    check("single tx_data held", 32'(tx_data), 32'h5A);

    // All four continuously valid from a fresh pointer.
    reset_n = 1'b0;
    tick(2);
    bus.req_data  = 32'h1312_1110;
    bus.req_valid = 4'b1111;
    reset_n       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_send("rr", 100, w);
      check("rr grant_id",  32'(grant_id),      32'(i % 4));
      check("rr tx_data",   32'(tx_data),       32'(8'h10 + i % 4));
      check("rr req_ready", 32'(bus.req_ready), 32'(1 << (i % 4)));
      if (i > 0) check("rr spacing", 32'(w + 1), 32'd45);
      if (i == 4) bus.req_valid = '0;
      tick(1);
    end
    wait_idle("rr", 100);

    // Transmitter never starts.
    model_dead    = 1'b1;
    bus.req_data  = 32'h0000_5AA5;
    bus.req_valid = 4'b0001;
    wait_send("timeout", 10, w);
    check("timeout grant_id", 32'(grant_id), 32'd0);
    check("timeout tx_data",  32'(tx_data),  32'hA5);
    bus.req_valid = '0;
    w = 0;
    while (err_timeout !== 1'b1 && w < 40) begin
      tick(1);
      w++;
    end
    check("timeout err delay", 32'(w),    32'd16);
    check("timeout back idle", 32'(busy), 32'd0);
    model_dead    = 1'b0;
    bus.req_valid = 4'b0011;
    tick(1);
    check("after timeout tx_send",   32'(tx_send),       32'd1);
    check("after timeout grant_id",  32'(grant_id),      32'd1);
    check("after timeout tx_data",   32'(tx_data),       32'h5A);
    check("after timeout req_ready", 32'(bus.req_ready), 32'h2);
    bus.req_valid = '0;
    tick(1);
    wait_idle("after timeout", 100);
    check("err sticky", 32'(err_timeout), 32'd1);

    // Requester 2 withdraws while requester 3 stays valid.
    bus.req_data  = 32'h3322_11C0;
    bus.req_valid = 4'b0001;
    wait_send("withdraw first", 10, w);
    check("withdraw first grant", 32'(grant_id), 32'd0);
    bus.req_valid = 4'b1100;
    tick(10);
    bus.req_valid = 4'b1000;
    r2 = rdy2_cnt;
    tick(1);
    wait_send("withdraw", 100, w);
    check("withdraw grant_id",  32'(grant_id),      32'd3);
    check("withdraw tx_data",   32'(tx_data),       32'h33);
    check("withdraw req_ready", 32'(bus.req_ready), 32'h8);
    check("withdraw no ready2", 32'(rdy2_cnt),      32'(r2));

    // Reset mid-frame with requester 0 pending.
    bus.req_valid = 4'b0001;
    tick(10);
    check("midreset busy before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    w    = 0;
    viol = 0;
    while (tx_complete !== 1'b1 && w < 100) begin
      if (tx_send !== 1'b0 || bus.req_ready !== 4'b0000) viol++;
      tick(1);
      w++;
    end
    check("midreset no grant while tx busy", 32'(viol), 32'd0);
    wait_send("midreset", 10, w);
    check("midreset send latency", 32'(w),             32'd1);
    check("midreset grant_id",     32'(grant_id),      32'd0);
    check("midreset tx_data",      32'(tx_data),       32'hC0);
    check("midreset req_ready",    32'(bus.req_ready), 32'h1);
    check("midreset err clear",    32'(err_timeout),   32'd0);
    bus.req_valid = '0;
    tick(1);
    wait_idle("midreset", 100);

    // Back-to-back bytes from requester 0 with a fast transmitter.
    drop_at       = 1;
    rise_at       = 2;
    bus.req_data  = 32'h0000_0077;
    bus.req_valid = 4'b0001;
    wait_send("b2b first", 10, w);
    for (int k = 1; k < 4; k++) begin
      tick(1);
      wait_send("b2b", 20, w);
      check("b2b spacing",  32'(w + 1),  32'd4);
      check("b2b grant_id", 32'(grant_id), 32'd0);
      check("b2b tx_data",  32'(tx_data),  32'h77);
    end
    bus.req_valid = '0;
    tick(1);
    wait_idle("b2b", 20);

    check("monitor strobe rules", 32'(send_bad),  32'd0);
    check("monitor ready onehot", 32'(ready_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
